// File: rtl/store_buffer_unit.sv
// Store formatter plus coalescing store buffer for the MEM stage.
// Formats SB/SH/SW, flags AdES, queues stores and drains them to DM.
module store_buffer_unit #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter bit MERGE_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       st_valid,
    input  logic [1:0]                 st_op,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [31:0]                st_data,
    input  logic                       req,
    output logic                       st_ready,
    output logic                       exc_ades,
    output logic                       dm_valid,
    output logic [ADDR_W-1:0]          dm_addr,
    output logic [3:0]                 dm_byteen,
    output logic [31:0]                dm_wdata,
    input  logic                       dm_ready,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WA_W  = ADDR_W - 2;

    localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] L_TWO   = CNT_W'(2);

    // Buffer storage: word address, byte enables, lane-aligned data.
    logic [WA_W-1:0]  r_addr [DEPTH];
    logic [3:0]       r_be   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [1:0]       w_off;
    logic [WA_W-1:0]  w_word;
    logic [WA_W-1:0]  w_ld_word;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic             w_mis;
    logic             w_op_ok;
    logic             w_deq;
    logic [PTR_W-1:0] w_tail_m1;
    logic             w_merge_ok;
    logic             w_acc;
    logic             w_push;
    logic             w_merge;
    logic [31:0]      w_merge_data;
    logic             w_hit;
    logic             w_empty;

    assign w_off     = st_addr[1:0];
    assign w_word    = st_addr[ADDR_W-1:2];
    assign w_ld_word = ld_addr[ADDR_W-1:2];
    assign w_empty   = (r_count == '0);

    // Lane placement and byte enables for the incoming store.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        unique case (st_op)
            2'b01: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {24'h0, st_data[7:0]} << {w_off, 3'b000};
            end
            2'b10: begin
                if (w_off[1]) begin
                    w_be    = 4'b1100;
                    w_wdata = {st_data[15:0], 16'h0};
                end else begin
                    w_be    = 4'b0011;
                    w_wdata = {16'h0, st_data[15:0]};
                end
            end
            2'b11: begin
                w_be    = 4'b1111;
                w_wdata = st_data;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = 32'h0;
            end
        endcase
    end

    // Alignment check: halfwords on even bytes, words on word boundaries.
    always_comb begin
        w_mis = 1'b0;
        unique case (st_op)
            2'b10:   w_mis = w_off[0];
            2'b11:   w_mis = |w_off;
            default: w_mis = 1'b0;
        endcase
    end

    assign w_op_ok  = st_valid & (st_op != 2'b00) & ~req;
    assign exc_ades = w_op_ok & w_mis;

    assign w_deq     = dm_valid & dm_ready;
    assign w_tail_m1 = r_tail - 1'b1;

    // The head entry is excluded (count>=2) so DM sees stable data.
    assign w_merge_ok = MERGE_EN
                      & (r_count >= L_TWO)
                      & (r_addr[w_tail_m1] == w_word);

    // Ready may follow dm_ready in the same cycle when full.
    assign st_ready = (r_count < L_DEPTH) | w_deq | w_merge_ok;

    assign w_acc   = w_op_ok & ~w_mis & st_ready;
    assign w_merge = w_acc & w_merge_ok;
    assign w_push  = w_acc & ~w_merge_ok;

    // Newly enabled bytes overwrite the tail entry, the rest are kept.
    always_comb begin
        w_merge_data = r_data[w_tail_m1];
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
                w_merge_data[8*b +: 8] = w_wdata[8*b +: 8];
            end
        end
    end

    // Load hazard: any buffered store to the same word stalls the load.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == w_ld_word)) begin
                w_hit = 1'b1;
            end
        end
    end

    // FIFO state: pop at head on deq, push or coalesce at tail on accept.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_be[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_deq) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            if (w_push) begin
                r_vld[r_tail]  <= 1'b1;
                r_addr[r_tail] <= w_word;
                r_be[r_tail]   <= w_be;
                r_data[r_tail] <= w_wdata;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_merge) begin
                r_be[w_tail_m1]   <= r_be[w_tail_m1] | w_be;
                r_data[w_tail_m1] <= w_merge_data;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_deq);
        end
    end

    assign dm_valid  = ~w_empty;
    assign dm_addr   = {r_addr[r_head], 2'b00};
    assign dm_byteen = r_be[r_head];
    assign dm_wdata  = r_data[r_head];
    assign ld_hit    = w_hit;
    assign empty     = w_empty;
    assign count     = r_count;

endmodule
